// File: rtl/bus_mem_responder_pkg.sv
// Shared widths, state encoding and window decode for the bus memory responder.
package bus_mem_responder_pkg;

    localparam int ADDR_SIZE0 = 15;
    localparam int DATA_SIZE0 = 31;
    localparam int ADDR_W     = ADDR_SIZE0 + 1;
    localparam int DATA_W     = DATA_SIZE0 + 1;

    typedef enum logic [2:0] {
        MRESP_IDLE    = 3'd0,
        MRESP_RD_WAIT = 3'd1,
        MRESP_RD_DONE = 3'd2,
        MRESP_WR_DONE = 3'd3,
        MRESP_RELEASE = 3'd4
    } mresp_state_t;

    // Window hit: everything above the RAM index must match the (aligned) base.
    function automatic logic addr_in_window(input logic [ADDR_SIZE0:0] a,
                                            input logic [ADDR_SIZE0:0] base,
                                            input int unsigned         depth_log2);
        return (a >> depth_log2) == (base >> depth_log2);
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous word RAM, write-enable plus registered read.
// Latency: rdata valid 1 cycle after idx is presented; no backpressure, no reset of contents.
module mem_resp_ram
    import bus_mem_responder_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int DATA_W = DATA_SIZE0 + 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the shared four-phase CPU bus; one decoded word window backed by a RAM.
// Latency: write_q->write_dn 1 cycle; read_q->read_dn 2 cycles, or 1+RD_LAT when MEM_RESP_WAIT_EN is defined.
// Backpressure: dn held until the initiator drops q, then one RELEASE turnaround cycle before IDLE.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int BASE_ADDR  = 0,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_SIZE0:0] addr,
    inout  wire  [DATA_SIZE0:0] data,
    input  logic                read_q,
    input  logic                write_q,
    output logic                read_dn,
    output logic                write_dn,
    output logic                sel,
    output logic                proto_err
);

    mresp_state_t          state;
    mresp_state_t          state_nxt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_SIZE0:0]   ram_rdata;
    logic                  hit;
    logic                  idle;
    logic                  ram_we;
    logic                  drive_data;

    assign idle = (state == MRESP_IDLE);
    assign hit  = addr_in_window(addr, ADDR_W'(BASE_ADDR), $unsigned(DEPTH_LOG2));

    // In IDLE the RAM sees the live address so a write commits on the request edge.
    assign ram_idx = idle ? addr[DEPTH_LOG2-1:0] : idx_q;
    assign ram_we  = idle && hit && write_q && !read_q;

    assign data = drive_data ? ram_rdata : 'z;

    mem_resp_ram #(
        .IDX_W  (DEPTH_LOG2),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (data),
        .rdata (ram_rdata)
    );

`ifdef MEM_RESP_WAIT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (idle) begin
            wait_cnt <= 4'(RD_LAT - 1);
        end else if (state == MRESP_RD_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
`else
    // Wait states are fixed at one cycle in this build; RD_LAT is carried only for interface parity.
    logic [3:0] unused_rd_lat;
    assign unused_rd_lat = 4'(RD_LAT);
`endif

    always_comb begin
        state_nxt  = state;
        read_dn    = 1'b0;
        write_dn   = 1'b0;
        sel        = 1'b0;
        drive_data = 1'b0;
        case (state)
            MRESP_IDLE: begin
                if (hit && read_q) begin
                    state_nxt = MRESP_RD_WAIT;
                end else if (hit && write_q) begin
                    state_nxt = MRESP_WR_DONE;
                end
            end
            MRESP_RD_WAIT: begin
                sel = 1'b1;
`ifdef MEM_RESP_WAIT_EN
                if (wait_cnt == '0) begin
                    state_nxt = MRESP_RD_DONE;
                end
`else
                state_nxt = MRESP_RD_DONE;
`endif
            end
            MRESP_RD_DONE: begin
                sel        = 1'b1;
                read_dn    = 1'b1;
                drive_data = 1'b1;
                if (!read_q) begin
                    state_nxt = MRESP_RELEASE;
                end
            end
            MRESP_WR_DONE: begin
                sel      = 1'b1;
                write_dn = 1'b1;
                if (!write_q) begin
                    state_nxt = MRESP_RELEASE;
                end
            end
            MRESP_RELEASE: begin
                state_nxt = MRESP_IDLE;
            end
            default: begin
                state_nxt = MRESP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MRESP_IDLE;
            idx_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (idle) begin
                idx_q <= addr[DEPTH_LOG2-1:0];
            end
            if (idle && hit && read_q && write_q) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboarded bench for bus_mem_responder: a pulldown on data makes a released bus read as zero.
module tb_bus_mem_responder;

    localparam int          DEPTH_LOG2 = 8;
    localparam int          RD_LAT     = 4;
    localparam logic [15:0] BASE       = 16'h0400;
`ifdef MEM_RESP_WAIT_EN
    localparam int RD_EXP = 1 + RD_LAT;
`else
    localparam int RD_EXP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    wire  [31:0] data;
    logic        read_q = 1'b0;
    logic        write_q = 1'b0;
    logic        read_dn, write_dn, sel, proto_err;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_dat = '0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    assign data = tb_drv ? tb_dat : 'z;
    pulldown (data);

    always #5 clk = ~clk;

    bus_mem_responder #(
        .BASE_ADDR  (int'(BASE)),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data      (data),
        .read_q    (read_q),
        .write_q   (write_q),
        .read_dn   (read_dn),
        .write_dn  (write_dn),
        .sel       (sel),
        .proto_err (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] v, input string tag);
        int lat;
        addr = a; tb_dat = v; tb_drv = 1'b1; write_q = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (write_dn) begin lat = i; break; end
        end
        model[int'(a)] = v;
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL %s write latency: got %0d want 1", tag, lat); end
        n_cmp++; if (sel !== 1'b1) begin n_err++; $display("FAIL %s sel during write: got %b want 1", tag, sel); end
        write_q = 1'b0; tb_drv = 1'b0;
        tick();
        n_cmp++; if (write_dn !== 1'b0) begin n_err++; $display("FAIL %s write_dn after drop: got %b want 0", tag, write_dn); end
        n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL %s sel in release: got %b want 0", tag, sel); end
        tick();
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        int          lat;
        logic [31:0] exp;
        exp_q.push_back(model[int'(a)]);
        addr = a; read_q = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (read_dn) begin lat = i; break; end
        end
        exp = exp_q.pop_front();
        n_cmp++; if (lat != RD_EXP) begin n_err++; $display("FAIL %s read latency: got %0d want %0d", tag, lat, RD_EXP); end
        if (lat > 0) begin
            n_cmp++; if (data !== exp) begin n_err++; $display("FAIL %s read data: got %h want %h", tag, data, exp); end
        end
        read_q = 1'b0;
        tick();
        n_cmp++; if (read_dn !== 1'b0) begin n_err++; $display("FAIL %s read_dn after drop: got %b want 0", tag, read_dn); end
        n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL %s bus not released: got %h want 0", tag, data); end
        n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL %s sel in release: got %b want 0", tag, sel); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (read_dn !== 1'b0) begin n_err++; $display("FAIL reset read_dn: got %b want 0", read_dn); end
        n_cmp++; if (write_dn !== 1'b0) begin n_err++; $display("FAIL reset write_dn: got %b want 0", write_dn); end
        n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL reset sel: got %b want 0", sel); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset proto_err: got %b want 0", proto_err); end
        n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL reset data released: got %h want 0", data); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(BASE + 16'd5, 32'hDEADBEEF, "wr_base5");
        do_read(BASE + 16'd5, "rd_base5");
        do_write(BASE, 32'h12345678, "wr_base0");
        do_write(BASE + 16'd255, 32'hA5A55A5A, "wr_last");
        do_read(BASE + 16'd255, "rd_last");
        do_read(BASE, "rd_base0");
        do_read(BASE + 16'd5, "rd_base5_again");
    endtask

    task automatic test_miss();
        addr = BASE + 16'd256; read_q = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (read_dn !== 1'b0) begin n_err++; $display("FAIL miss read_dn cyc %0d: got %b want 0", i, read_dn); end
            n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL miss sel cyc %0d: got %b want 0", i, sel); end
            n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL miss data cyc %0d: got %h want 0", i, data); end
        end
        read_q = 1'b0;
        addr = BASE - 16'd1; tb_dat = 32'hFFFF0000; tb_drv = 1'b1; write_q = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (write_dn !== 1'b0) begin n_err++; $display("FAIL miss write_dn cyc %0d: got %b want 0", i, write_dn); end
        end
        write_q = 1'b0; tb_drv = 1'b0;
        tick();
        do_read(BASE + 16'd255, "rd_last_after_miss");
    endtask

    task automatic test_both();
        int lat;
        logic [31:0] exp;
        do_write(BASE + 16'd1, 32'h11111111, "wr_base1");
        exp_q.push_back(model[int'(BASE + 16'd1)]);
        addr = BASE + 16'd1; tb_dat = 32'hBAD0BAD0; tb_drv = 1'b1;
        read_q = 1'b1; write_q = 1'b1;
        tick();
        tb_drv = 1'b0;
        lat = (read_dn === 1'b1) ? 1 : -1;
        for (int i = 2; i <= 40 && lat < 0; i++) begin
            tick();
            if (read_dn) lat = i;
        end
        exp = exp_q.pop_front();
        n_cmp++; if (lat != RD_EXP) begin n_err++; $display("FAIL both read latency: got %0d want %0d", lat, RD_EXP); end
        n_cmp++; if (data !== exp) begin n_err++; $display("FAIL both read data: got %h want %h", data, exp); end
        n_cmp++; if (write_dn !== 1'b0) begin n_err++; $display("FAIL both write_dn: got %b want 0", write_dn); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL both proto_err: got %b want 1", proto_err); end
        read_q = 1'b0; write_q = 1'b0;
        repeat (2) tick();
        do_read(BASE + 16'd1, "rd_base1_unchanged");
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_early_drop();
        int first, width;
        logic [31:0] exp;
        do_write(BASE + 16'd7, 32'h0BADF00D, "wr_base7");
        exp_q.push_back(model[int'(BASE + 16'd7)]);
        addr = BASE + 16'd7; read_q = 1'b1;
        tick();
        read_q = 1'b0;
        addr = BASE + 16'd9;
        first = -1; width = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (read_dn) begin
                width++;
                if (first < 0) begin
                    first = i;
                    exp = exp_q.pop_front();
                    n_cmp++; if (data !== exp) begin n_err++; $display("FAIL early data: got %h want %h", data, exp); end
                end
            end else if (first >= 0) begin
                n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL early release sel: got %b want 0", sel); end
                break;
            end
        end
        if (first < 0) void'(exp_q.pop_front());
        n_cmp++; if (first != RD_EXP - 1) begin n_err++; $display("FAIL early dn start: got %0d want %0d", first, RD_EXP - 1); end
        n_cmp++; if (width != 1) begin n_err++; $display("FAIL early dn width: got %0d want 1", width); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp;
        exp_q.push_back(model[int'(BASE + 16'd5)]);
        addr = BASE + 16'd5; read_q = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin tick(); if (read_dn) begin lat = i; break; end end
        exp = exp_q.pop_front();
        n_cmp++; if (data !== exp) begin n_err++; $display("FAIL b2b first data: got %h want %h", data, exp); end
        read_q = 1'b0;
        tick();
        exp_q.push_back(model[int'(BASE)]);
        addr = BASE; read_q = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin tick(); if (read_dn) begin lat = i; break; end end
        exp = exp_q.pop_front();
        n_cmp++; if (lat != RD_EXP + 1) begin n_err++; $display("FAIL b2b second latency: got %0d want %0d", lat, RD_EXP + 1); end
        n_cmp++; if (data !== exp) begin n_err++; $display("FAIL b2b second data: got %h want %h", data, exp); end
        read_q = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_read();
        int lat;
        logic [31:0] exp;
        exp_q.push_back(model[int'(BASE + 16'd5)]);
        addr = BASE + 16'd5; read_q = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin tick(); if (read_dn) begin lat = i; break; end end
        exp = exp_q.pop_front();
        n_cmp++; if (data !== exp) begin n_err++; $display("FAIL midrst pre data: got %h want %h", data, exp); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (read_dn !== 1'b0) begin n_err++; $display("FAIL midrst read_dn async: got %b want 0", read_dn); end
        n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL midrst data async: got %h want 0", data); end
        n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL midrst sel async: got %b want 0", sel); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL midrst proto_err: got %b want 0", proto_err); end
        read_q = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_read(BASE + 16'd5, "rd_after_reset");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_miss();
        test_both();
        test_early_drop();
        test_back_to_back();
        test_reset_mid_read();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
